// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester and RAM-side signal bundle for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8
);
    logic               i_req;
    logic [A_WIDTH-1:0] i_addr;
    logic               i_grant;
    logic               i_odv;
    logic [D_WIDTH-1:0] i_data;
    logic               d_req;
    logic               d_we;
    logic [A_WIDTH-1:0] d_addr;
    logic [D_WIDTH-1:0] d_wdata;
    logic               d_grant;
    logic               d_odv;
    logic [D_WIDTH-1:0] d_rdata;
    logic [A_WIDTH-1:0] mem_addr;
    logic               mem_re;
    logic               mem_we;
    logic [D_WIDTH-1:0] mem_wdata;
    logic [D_WIDTH-1:0] mem_rdata;
    logic               busy;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_grant, i_odv, i_data, d_grant, d_odv, d_rdata,
               mem_addr, mem_re, mem_we, mem_wdata, busy
    );

    // Requesters and RAM side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_grant, i_odv, i_data, d_grant, d_odv, d_rdata,
               mem_addr, mem_re, mem_we, mem_wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single-port RAM between I-refill and D-access ports;
//               D has priority, a starvation counter forces I periodically.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int D_WIDTH      = 8,
    parameter int A_WIDTH      = 8,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic          g_clk,
    input  wire logic          g_clr,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] c_starve_max = 4'(STARVE_LIMIT);
    localparam logic [1:0] c_lat_init   = 2'(RD_LAT - 1);

    state_t             state_q, state_d;
    logic [3:0]         starve_cnt_q, starve_cnt_d;
    logic [1:0]         lat_cnt_q, lat_cnt_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [D_WIDTH-1:0] wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               owner_d_q, owner_d_d;   // 1 = D-side owns the access

    logic               w_pick_d;
    logic               w_i_grant, w_d_grant, w_i_odv, w_d_odv;
    logic               w_mem_re, w_mem_we;
    logic [A_WIDTH-1:0] w_mem_addr;
    logic [D_WIDTH-1:0] w_mem_wdata, w_i_data, w_d_rdata;

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            lat_cnt_q    <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            owner_d_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            owner_d_q    <= owner_d_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        owner_d_d    = owner_d_q;
        w_pick_d     = 1'b0;
        w_i_grant    = 1'b0;
        w_d_grant    = 1'b0;
        w_i_odv      = 1'b0;
        w_d_odv      = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        w_i_data     = '0;
        w_d_rdata    = '0;

        case (state_q)
            IDLE: begin
                // D wins unless I is pending and has waited out its quota
                w_pick_d = bus.d_req && (!bus.i_req || (starve_cnt_q < c_starve_max));
                if (w_pick_d) begin
                    state_d   = ISSUE;
                    owner_d_d = 1'b1;
                    addr_d    = bus.d_addr;
                    we_d      = bus.d_we;
                    wdata_d   = bus.d_wdata;
                    if (bus.i_req)
                        starve_cnt_d = (starve_cnt_q == c_starve_max) ? c_starve_max
                                                                      : starve_cnt_q + 4'd1;
                    else
                        starve_cnt_d = '0;
                end else if (bus.i_req) begin
                    state_d      = ISSUE;
                    owner_d_d    = 1'b0;
                    addr_d       = bus.i_addr;
                    we_d         = 1'b0;
                    wdata_d      = '0;
                    starve_cnt_d = '0;
                end
            end
            ISSUE: begin
                w_mem_addr  = addr_q;
                w_mem_wdata = wdata_q;
                w_mem_re    = !we_q;
                w_mem_we    = we_q;
                w_i_grant   = !owner_d_q;
                w_d_grant   = owner_d_q;
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    state_d   = WAIT;
                    lat_cnt_d = c_lat_init;
                end
            end
            WAIT: begin
                w_mem_addr = addr_q;
                w_mem_re   = 1'b1;
                if (lat_cnt_q == 2'd0)
                    state_d = DONE;
                else
                    lat_cnt_d = lat_cnt_q - 2'd1;
            end
            DONE: begin
                w_i_odv = !owner_d_q;
                w_d_odv = owner_d_q;
                if (!we_q) begin
                    if (owner_d_q)
                        w_d_rdata = bus.mem_rdata;
                    else
                        w_i_data  = bus.mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.i_grant   = w_i_grant;
    assign bus.d_grant   = w_d_grant;
    assign bus.i_odv     = w_i_odv;
    assign bus.d_odv     = w_d_odv;
    assign bus.i_data    = w_i_data;
    assign bus.d_rdata   = w_d_rdata;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_re    = w_mem_re;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed vector bench for mem_port_arbiter (rd_lat 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk  = 1'b0;
    logic clr1 = 1'b1;
    logic clr2 = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.D_WIDTH(8), .A_WIDTH(8)) b1 ();
    mem_port_arbiter_if #(.D_WIDTH(8), .A_WIDTH(8)) b2 ();

    mem_port_arbiter #(.D_WIDTH(8), .A_WIDTH(8), .RD_LAT(1), .STARVE_LIMIT(4)) u_dut1 (
        .g_clk (clk),
        .g_clr (clr1),
        .bus   (b1.slave)
    );

    mem_port_arbiter #(.D_WIDTH(8), .A_WIDTH(8), .RD_LAT(3), .STARVE_LIMIT(4)) u_dut2 (
        .g_clk (clk),
        .g_clr (clr2),
        .bus   (b2.slave)
    );

    logic [7:0] ram1 [256];
    logic [7:0] ram2 [256];

    always @(posedge clk) begin
        if (b1.mem_we) ram1[b1.mem_addr] <= b1.mem_wdata;
        if (b1.mem_re) b1.mem_rdata <= ram1[b1.mem_addr];
        if (b2.mem_we) ram2[b2.mem_addr] <= b2.mem_wdata;
        if (b2.mem_re) b2.mem_rdata <= ram2[b2.mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [38:0] outs1();
        return {b1.i_grant, b1.d_grant, b1.i_odv, b1.d_odv, b1.busy, b1.mem_re, b1.mem_we,
                b1.mem_addr, b1.mem_wdata, b1.i_data, b1.d_rdata};
    endfunction

    function automatic logic [38:0] outs2();
        return {b2.i_grant, b2.d_grant, b2.i_odv, b2.d_odv, b2.busy, b2.mem_re, b2.mem_we,
                b2.mem_addr, b2.mem_wdata, b2.i_data, b2.d_rdata};
    endfunction

    // Mutual-exclusion invariants, every cycle while out of reset
    always @(negedge clk) begin
        if (!clr1) begin
            chk("inv1_mem_re_we", 64'(b1.mem_re & b1.mem_we), 64'd0);
            chk("inv1_grants",    64'(b1.i_grant & b1.d_grant), 64'd0);
            chk("inv1_odvs",      64'(b1.i_odv & b1.d_odv), 64'd0);
        end
        if (!clr2)
            chk("inv2_mem_re_we", 64'(b2.mem_re & b2.mem_we), 64'd0);
    end

    typedef struct {
        logic       i_req;
        logic [7:0] i_addr;
        logic       d_req;
        logic       d_we;
        logic [7:0] d_addr;
        logic [7:0] d_wdata;
        logic [38:0] exp;
    } vec_t;

    function automatic vec_t mk(logic ir, logic [7:0] ia, logic dr, logic dw, logic [7:0] da,
                                logic [7:0] dd, logic igr, logic dgr, logic iodv, logic dodv,
                                logic bsy, logic mre, logic mwe, logic [7:0] ma,
                                logic [7:0] mwd, logic [7:0] id, logic [7:0] drd);
        vec_t v;
        v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
        v.exp = {igr, dgr, iodv, dodv, bsy, mre, mwe, ma, mwd, id, drd};
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        string exp_seq;
        string got_seq;
        int    n;

        for (int i = 0; i < 256; i++) begin
            ram1[i] = 8'h00;
            ram2[i] = 8'h00;
        end
        ram1[8'h10] = 8'hA5;
        ram1[8'h05] = 8'h5A;
        ram1[8'h06] = 8'h66;
        ram2[8'h7F] = 8'hC3;

        b1.i_req = 0; b1.i_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
        b2.i_req = 0; b2.i_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0;

        // Each vector: inputs driven for one cycle, outputs expected after the next edge
        //            ir ia    dr dw da     dd     ig dg io do bs re we ma     mwd    id     drd
        vecs[0]  = mk(1, 8'h10, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 1, 1, 0, 8'h10, 8'h00, 8'h00, 8'h00);
        vecs[1]  = mk(1, 8'h10, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h10, 8'h00, 8'h00, 8'h00);
        vecs[2]  = mk(1, 8'h10, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h00, 8'h00, 8'hA5, 8'h00);
        vecs[3]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[4]  = mk(0, 8'h00, 1, 1, 8'h20, 8'h3C, 0, 1, 0, 0, 1, 0, 1, 8'h20, 8'h3C, 8'h00, 8'h00);
        vecs[5]  = mk(0, 8'h00, 1, 1, 8'h20, 8'h3C, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[6]  = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[7]  = mk(0, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 0, 0, 1, 1, 0, 8'h20, 8'h00, 8'h00, 8'h00);
        vecs[8]  = mk(0, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h20, 8'h00, 8'h00, 8'h00);
        vecs[9]  = mk(0, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h3C);
        vecs[10] = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
        vecs[11] = mk(0, 8'h00, 1, 0, 8'h05, 8'h00, 0, 1, 0, 0, 1, 1, 0, 8'h05, 8'h00, 8'h00, 8'h00);
        vecs[12] = mk(0, 8'h00, 1, 0, 8'h06, 8'h00, 0, 0, 0, 0, 1, 1, 0, 8'h05, 8'h00, 8'h00, 8'h00);
        vecs[13] = mk(0, 8'h00, 1, 0, 8'h06, 8'h00, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h5A);
        vecs[14] = mk(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("reset_outs_dut1", 64'(outs1()), 64'd0);
        chk("reset_outs_dut2", 64'(outs2()), 64'd0);
        clr1 = 1'b0;
        clr2 = 1'b0;

        foreach (vecs[k]) begin
            b1.i_req = vecs[k].i_req; b1.i_addr = vecs[k].i_addr;
            b1.d_req = vecs[k].d_req; b1.d_we   = vecs[k].d_we;
            b1.d_addr = vecs[k].d_addr; b1.d_wdata = vecs[k].d_wdata;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d", k), 64'(outs1()), 64'(vecs[k].exp));
        end

        // Starvation: both requesters held continuously
        b1.i_req = 1; b1.i_addr = 8'h10;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 8'h20;
        exp_seq = "DDDDIDDDDI";
        got_seq = "";
        n = 0;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (b1.d_grant) begin got_seq = {got_seq, "D"}; n++; end
            if (b1.i_grant) begin got_seq = {got_seq, "I"}; n++; end
        end
        chk("starve_grant_count", 64'(n), 64'd10);
        for (int g = 0; g < 10; g++) begin
            byte e, a;
            e = exp_seq[g];
            a = (g < got_seq.len()) ? got_seq[g] : 8'h3F;
            chk($sformatf("starve_grant%0d", g), 64'(a), 64'(e));
        end
        b1.i_req = 0; b1.d_req = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("starve_back_idle", 64'(b1.busy), 64'd0);

        // Reset during WAIT of an I read
        b1.i_req = 1; b1.i_addr = 8'h10;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pre_igrant", 64'(b1.i_grant), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_wait", 64'({b1.busy, b1.mem_re}), 64'b11);
        clr1 = 1'b1;
        #1;
        chk("rst_async_outs", 64'(outs1()), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_no_iodv", 64'({b1.i_odv, b1.busy}), 64'd0);
        clr1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_fresh_igrant", 64'({b1.i_grant, b1.mem_addr}), {55'd0, 1'b1, 8'h10});
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_after_iodv", 64'({b1.i_odv, b1.i_data}), {55'd0, 1'b1, 8'hA5});
        b1.i_req = 0;

        // rd_lat = 3 D read
        b2.d_req = 1; b2.d_we = 0; b2.d_addr = 8'h7F;
        @(posedge clk);
        @(negedge clk);
        chk("lat3_issue", 64'({b2.d_grant, b2.mem_re, b2.mem_addr}), {54'd0, 2'b11, 8'h7F});
        b2.d_addr = 8'h00;
        for (int w = 1; w <= 3; w++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("lat3_wait%0d", w), 64'({b2.d_odv, b2.mem_re, b2.mem_addr}),
                {54'd0, 2'b01, 8'h7F});
        end
        @(posedge clk);
        @(negedge clk);
        chk("lat3_done", 64'({b2.d_odv, b2.mem_re, b2.d_rdata}), {54'd0, 2'b10, 8'hC3});
        b2.d_req = 0;
        @(posedge clk);
        @(negedge clk);
        chk("lat3_idle", 64'(b2.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 256-entry RAM between two requesters: the instruction-cache refill port (I-side) and the stage-three data access port (D-side).
- Sequences each access as issue, then wait for read latency, then a valid strobe.
- Grants D-side by priority, with a starvation counter that guarantees I-side forward progress.
- Sits between the I/D caches (or the D stage directly) and the shared RAM, and generates the i_odv/d_odv strobes the controller stalls on.

Parameters:
- d_width, 8: data width of the RAM and of both requesters.
- a_width, 8: address width.
- rd_lat, 1: RAM cycles from the read-issue edge to valid mem_rdata; legal range 1..3.
- starve_limit, 4: consecutive D grants while i_req is pending before I-side is forced; legal range 1..15.

Ports:
- g_clk, input, 1: system clock, rising edge.
- g_clr, input, 1: asynchronous active-high reset.
- i_req, input, 1: I-side read request; held until i_odv.
- i_addr, input, a_width: I-side address.
- i_grant, output, 1: one-cycle pulse in the I issue cycle.
- i_odv, output, 1: one-cycle pulse; i_data valid.
- i_data, output, d_width: read data to I-side.
- d_req, input, 1: D-side request; held until d_odv.
- d_we, input, 1: D-side access type; 1 = write, 0 = read.
- d_addr, input, a_width: D-side address.
- d_wdata, input, d_width: D-side write data.
- d_grant, output, 1: one-cycle pulse in the D issue cycle.
- d_odv, output, 1: one-cycle pulse; read data valid, or write done.
- d_rdata, output, d_width: read data to D-side.
- mem_addr, output, a_width: RAM address.
- mem_re, output, 1: RAM read strobe.
- mem_we, output, 1: RAM write strobe.
- mem_wdata, output, d_width: RAM write data.
- mem_rdata, input, d_width: RAM read data.
- busy, output, 1: high in every non-IDLE state.

Behaviour:
- Reset (g_clr=1, asynchronous):
  - FSM goes to IDLE and starve_cnt goes to 0.
  - All outputs are 0, including mem_addr, mem_wdata, i_data and d_rdata.
  - Reset mid-transaction abandons the access. No odv is issued. A write that is in its issue cycle when reset asserts is not guaranteed to commit.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: samples i_req and d_req at each rising edge. Selection:
  - Only one request: that requester wins.
  - Both requests, starve_cnt < starve_limit: D wins.
  - Both requests, starve_cnt == starve_limit: I wins.
  - Winner goes to ISSUE. Its address, we and wdata are latched into internal registers, and the owner is recorded.
- ISSUE (1 cycle):
  - mem_addr and mem_wdata come from the latched registers.
  - mem_re = !we_latched and mem_we = we_latched (I-side is always a read).
  - The owner's grant pulses.
  - Write: go to DONE. Read: go to WAIT with lat_cnt = rd_lat-1.
- WAIT: mem_addr is held and mem_re is held high. Decrement lat_cnt; when it reaches 0, go to DONE.
- DONE (1 cycle):
  - The owner's odv = 1.
  - For a read, the owner's data output = mem_rdata (combinational pass-through, valid only while odv is high).
  - The non-owner's data output holds 0.
  - Next state is IDLE.
- Read latency: a read issued at edge t gives odv high in the cycle after edge t+rd_lat. With rd_lat=1, ISSUE, WAIT and DONE are 3 cycles; the RAM samples the address at the edge entering WAIT, and WAIT exits immediately at lat_cnt=0.
- Write: odv high 2 cycles after leaving IDLE; the write commits at the edge ending ISSUE.
- Back-to-back: minimum 1 IDLE cycle between transactions.
  - A requester drops req at the edge on which it sees odv.
  - A req still high in IDLE after that edge is a new request.
- Starvation counter, updated on each grant decision:
  - D granted while i_req=1: starve_cnt +1, saturating at starve_limit.
  - I granted: starve_cnt = 0.
  - D granted while i_req=0: starve_cnt = 0.
- Request withdrawn after ISSUE: the access completes and odv still pulses. Requesters must not withdraw; this is a protocol violation, but behaviour is defined.
- Inputs are ignored outside IDLE. Address and data changes after the grant do not affect the access in flight.
- Invariants:
  - mem_re and mem_we are never both 1.
  - i_grant and d_grant are never both 1.
  - i_odv and d_odv are never both 1.

Test Plan:
- Single I read at 0x10 with RAM[0x10]=0xA5, rd_lat=1: i_grant in cycle 1; i_odv and i_data=0xA5 in cycle 3. d_odv stays 0 and busy=1 for cycles 1–3.
- D write 0x3C to 0x20, then D read 0x20: mem_we pulses once with mem_addr=0x20; d_odv comes 2 cycles after IDLE; the read returns d_rdata=0x3C. mem_re and mem_we are never both high.
- i_req and d_req held continuously with starve_limit=4: grant sequence is D,D,D,D,I,D,D,D,D,I. starve_cnt returns to 0 after each I grant.
- rd_lat=3, D read of 0x7F: mem_re and mem_addr=0x7F stay high 3 cycles; d_odv appears exactly 4 cycles after the ISSUE entry edge.
- g_clr pulsed during WAIT of an I read: all outputs go 0 immediately and no i_odv follows. After release with i_req held, a fresh i_grant arrives 1 cycle later.
- d_addr changed from 0x05 to 0x06 in the ISSUE cycle: mem_addr stays 0x05 for the whole access.
